// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC cosine datapath: default sizes, gain K and
// the arctangent table, plus a float-field view used by the converters.
package cordic_pkg;

  localparam int WIDTH_DEF  = 24;
  localparam int ITER_DEF   = 18;
  localparam int TABLE_LEN  = 32;
  localparam int TABLE_FRAC = 24;

  typedef struct packed {
    logic        sign;
    logic [7:0]  expo;
    logic [22:0] man;
  } fp32_t;

  // Constants are stored with 24 fractional bits and rescaled to the datapath width.
  localparam logic [31:0] K_Q24 = 32'h009B74ED;

  localparam logic [31:0] ATAN_Q24 [TABLE_LEN] = '{
    32'h00C90FDB, 32'h0076B19C, 32'h003EB6EC, 32'h001FD5BB,
    32'h000FFAAE, 32'h0007FF55, 32'h0003FFEB, 32'h0001FFFD,
    32'h00010000, 32'h00008000, 32'h00004000, 32'h00002000,
    32'h00001000, 32'h00000800, 32'h00000400, 32'h00000200,
    32'h00000100, 32'h00000080, 32'h00000040, 32'h00000020,
    32'h00000010, 32'h00000008, 32'h00000004, 32'h00000002,
    32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000
  };

  function automatic logic [63:0] scale_q24(input logic [31:0] v, input int width);
    if (width >= TABLE_FRAC)
      return longint'(v) <<< (width - TABLE_FRAC);
    else
      return (longint'(v) + (longint'(1) <<< (TABLE_FRAC - 1 - width))) >>> (TABLE_FRAC - width);
  endfunction

  function automatic logic [63:0] atan_fixed(input int i, input int width);
    return scale_q24(ATAN_Q24[i], width);
  endfunction

  function automatic logic [63:0] k_fixed(input int width);
    return scale_q24(K_Q24, width);
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One rotation-mode CORDIC micro-rotation; the shift amount and arctangent
// constant are fixed per instance.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int                      WIDTH = WIDTH_DEF,
  parameter int                      SHIFT = 0,
  parameter logic signed [WIDTH+1:0] ATAN  = '0
) (
  input  logic signed [WIDTH+1:0] x_i,
  input  logic signed [WIDTH+1:0] y_i,
  input  logic signed [WIDTH+1:0] w_i,
  output logic signed [WIDTH+1:0] x_o,
  output logic signed [WIDTH+1:0] y_o,
  output logic signed [WIDTH+1:0] w_o
);

  logic signed [WIDTH+1:0] x_sh;
  logic signed [WIDTH+1:0] y_sh;

  assign x_sh = x_i >>> SHIFT;
  assign y_sh = y_i >>> SHIFT;

  always_comb begin
    // NOTE: every output is assigned on both branches, so no latch can be inferred.
    if (!w_i[WIDTH+1]) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      w_o = w_i - ATAN;
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      w_o = w_i + ATAN;
    end
  end

endmodule

// File: rtl/cosine_iterator.sv
// Pipelined cosine: float angle is registered, converted to fixed point, rotated
// through an unrolled CORDIC chain, and the final x is registered back as a float.
module cosine_iterator
  import cordic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = ITER_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            angle,
  output logic [31:0]            result,
  output logic [WIDTH+1:0]       theta,
  output logic [31:0][WIDTH+1:0] x_s,
  output logic [31:0][WIDTH+1:0] w_s
);

  localparam int DW = WIDTH + 2;
  typedef logic signed [DW-1:0] word_t;

  localparam word_t POS_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam word_t NEG_MAX = {1'b1, {(DW-1){1'b0}}};

  fp32_t       angle_q;
  logic [31:0] result_q;
  word_t       theta_w;
  word_t       x_c [ITER+1];
  word_t       y_c [ITER+1];
  word_t       w_c [ITER+1];

  function automatic word_t float_to_fixed(input fp32_t f);
    logic [WIDTH+23:0] big;
    logic [7:0]        rsh;
    word_t             mag;
    if (f.expo == 8'd0)
      return '0;
    if (f.expo >= 8'd128)
      return f.sign ? NEG_MAX : POS_MAX;
    // (1.man * 2^WIDTH) * 2^(expo-150); expo <= 127 keeps the shift right-only.
    big = {1'b1, f.man, {WIDTH{1'b0}}};
    rsh = 8'd150 - f.expo;
    mag = word_t'(big >> rsh);
    return f.sign ? -mag : mag;
  endfunction

  function automatic logic [31:0] fixed_to_float(input word_t x);
    logic              sign;
    logic [DW-1:0]     mag;
    logic [DW+22:0]    norm;
    logic [7:0]        e;
    int                lead;
    sign = x[DW-1];
    mag  = sign ? DW'(-x) : DW'(x);
    if (mag == '0)
      return 32'h0000_0000;
    lead = 0;
    for (int b = 0; b < DW; b++)
      if (mag[b]) lead = b;
    norm = {mag, 23'd0} << (DW - 1 - lead);
    e    = 8'(127 + lead - WIDTH);
    return {sign, e, norm[DW+21 -: 23]};
  endfunction

  assign theta_w = float_to_fixed(angle_q);
  assign theta   = theta_w;

  assign x_c[0] = word_t'(k_fixed(WIDTH));
  assign y_c[0] = '0;
  assign w_c[0] = theta_w;

  for (genvar g = 0; g < ITER; g++) begin : g_stage
    cordic_stage #(
      .WIDTH (WIDTH),
      .SHIFT (g),
      .ATAN  (word_t'(atan_fixed(g, WIDTH)))
    ) u_stage (
      .x_i (x_c[g]),
      .y_i (y_c[g]),
      .w_i (w_c[g]),
      .x_o (x_c[g+1]),
      .y_o (y_c[g+1]),
      .w_o (w_c[g+1])
    );
  end

  // The final sine term has no consumer in a cosine-only block.
  logic unused_y_final;
  assign unused_y_final = ^y_c[ITER];

  for (genvar k = 0; k < 32; k++) begin : g_dbg
    if (k < ITER) begin : g_live
      assign x_s[k] = x_c[k];
      assign w_s[k] = w_c[k];
    end else begin : g_hold
      assign x_s[k] = x_c[ITER];
      assign w_s[k] = w_c[ITER];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      angle_q  <= '0;
      result_q <= '0;
    end else begin
      angle_q  <= angle;
      result_q <= fixed_to_float(x_c[ITER]);
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_cosine_iterator.sv
// Self-checking bench for cosine_iterator: directed corner angles plus random
// floats, checked against real-valued cosine and float decoding.
module tb_cosine_iterator;

  localparam int     WIDTH   = 24;
  localparam int     ITER    = 18;
  localparam int     DW      = WIDTH + 2;
  localparam real    SCALE   = 16777216.0;
  localparam longint TOL_ACC = 512;
  localparam longint TOL_RES = 256;
  localparam longint K_EXP   = 64'h9B74ED;
  localparam longint SAT_MAG = 33554431;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [31:0]            angle = 32'h0;
  logic [31:0]            result;
  logic [DW-1:0]          theta;
  logic [31:0][DW-1:0]    x_s;
  logic [31:0][DW-1:0]    w_s;

  int  tests_run    = 0;
  int  tests_failed = 0;
  real sigma;

  logic [31:0] hist1, hist2;
  bit          v1 = 1'b0, v2 = 1'b0;

  cosine_iterator #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk    (clk),
    .reset  (reset),
    .angle  (angle),
    .result (result),
    .theta  (theta),
    .x_s    (x_s),
    .w_s    (w_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint want, input longint tol);
    longint diff;
    tests_run++;
    diff = got - want;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      tests_failed++;
      $display("FAIL %s: got %0d want %0d (tol %0d) at %0t", tag, got, want, tol, $time);
    end
  endtask

  function automatic real pow2(input int n);
    real p;
    p = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
    else        for (int i = 0; i < -n; i++) p = p / 2.0;
    return p;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) m = real'(b[22:0]) * pow2(-149);
    else        m = real'({1'b1, b[22:0]}) * pow2(e - 150);
    return b[31] ? -m : m;
  endfunction

  function automatic longint want_theta(input logic [31:0] b);
    real    r, a;
    longint t;
    r = f2r(b);
    a = (r < 0.0) ? -r : r;
    if (a >= 2.0) t = SAT_MAG;
    else          t = longint'($rtoi(a * SCALE));
    return (r < 0.0) ? -t : t;
  endfunction

  // Expected cosine (Q24): inputs beyond the total rotation settle at that limit.
  function automatic longint want_cos(input longint th);
    real a;
    a = real'(th) / SCALE;
    if (a >  sigma) a =  sigma;
    if (a < -sigma) a = -sigma;
    return longint'($cos(a) * SCALE);
  endfunction

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint absl(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic check_stage1(input logic [31:0] a);
    longint th;
    longint tol;
    bit     conv;
    th   = want_theta(a);
    tol  = (th == -SAT_MAG) ? 1 : 0;
    conv = (absl(th) < 0) ? 1'b0 : (real'(absl(th)) / SCALE <= sigma - 1.0e-4);
    check($sformatf("theta[%h]", a), sx(theta), th, tol);
    check($sformatf("w_s0[%h]", a), sx(w_s[0]), th, tol);
    check($sformatf("x_s0[%h]", a), sx(x_s[0]), K_EXP, 0);
    check($sformatf("x_s31[%h]", a), sx(x_s[31]), want_cos(th), TOL_ACC);
    if (conv) begin
      check($sformatf("w_s17[%h]", a), absl(sx(w_s[17])), 0, TOL_RES);
      check($sformatf("w_s31[%h]", a), absl(sx(w_s[31])), 0, TOL_RES);
    end
  endtask

  task automatic check_stage2(input logic [31:0] a);
    check($sformatf("result[%h]", a), longint'(f2r(result) * SCALE), want_cos(want_theta(a)), TOL_ACC);
  endtask

  task automatic step(input logic [31:0] next);
    @(negedge clk);
    if (v1) check_stage1(hist1);
    if (v2) check_stage2(hist2);
    hist2 = hist1;
    v2    = v1;
    hist1 = next;
    v1    = 1'b1;
    angle = next;
  endtask

  function automatic logic [31:0] rand_angle();
    logic [31:0] b;
    b[31]    = 1'($urandom_range(0, 1));
    b[30:23] = 8'($urandom_range(110, 128));
    b[22:0]  = 23'($urandom);
    return b;
  endfunction

  logic [31:0] directed [14] = '{
    32'h3F800000, 32'hBF800000, 32'h00000000, 32'h33800000,
    32'h33000000, 32'h3F000000, 32'h3FDF0000, 32'h80000000,
    32'h00400000, 32'h40400000, 32'hC0400000, 32'h7F800000,
    32'hFF800000, 32'h3FE00000
  };

  initial begin
    sigma = 0.0;
    for (int i = 0; i < ITER; i++) sigma = sigma + $atan(pow2(-i));

    #1 reset = 1'b1;
    #2;
    check("reset_result", longint'(result), 0, 0);
    check("reset_theta", sx(theta), 0, 0);
    check("reset_x_s0", sx(x_s[0]), K_EXP, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (directed[i]) step(directed[i]);
    step(32'h3F800000);

    // Reset mid-stream clears outputs without waiting for a clock edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_result", longint'(result), 0, 0);
    check("midrst_theta", sx(theta), 0, 0);
    v1 = 1'b0;
    v2 = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 300; n++) step(rand_angle());
    step(32'h3F000000);
    step(32'h3F000000);
    step(32'h3F000000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
